// File: rtl/bf8b_mem_pkg.sv
// Shared widths and the read-owner encoding for the eightbit core memory port.
// ARB_ROUND_ROBIN_EN selects alternating arbitration in users of this package.
package bf8b_mem_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int STARVE_MAX_DEF = 3;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_IF    = 2'd1,
    SRC_LS_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant pick between fetch and load/store.
// ARB_ROUND_ROBIN_EN: tie goes to the source that did not win last; otherwise LS wins unless IF is starved.
module mem_arb_pick
  import bf8b_mem_pkg::*;
`ifndef ARB_ROUND_ROBIN_EN
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
)
`endif
(
  input  logic             if_req,
  input  logic             ls_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic             last_winner_ls,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             if_gnt,
  output logic             ls_gnt
);

  logic if_prio;

`ifdef ARB_ROUND_ROBIN_EN
  assign if_prio = last_winner_ls;
`else
  assign if_prio = (starve_cnt == CNT_W'(STARVE_MAX));
`endif

  always_comb begin
    ls_gnt = ls_req & ~(if_req & if_prio);
    if_gnt = if_req & ~ls_gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges instruction fetch and load/store onto one single-port byte memory, one access per cycle.
// ARB_ROUND_ROBIN_EN defined: alternating tie-break; undefined: LS priority with starvation escape.
//
// owner     | meaning
// SRC_NONE  | no read returns this cycle
// SRC_IF    | mem_rdata belongs to the fetch granted last cycle
// SRC_LS_RD | mem_rdata belongs to the load granted last cycle
module mem_port_arbiter
  import bf8b_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e            owner, owner_nxt;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic              if_req_v, ls_req_v;

  // Requests are masked during reset so nothing reaches the memory.
  assign if_req_v = if_req & ~rst;
  assign ls_req_v = ls_req & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner_ls;

  always_ff @(posedge clk) begin
    if (rst)         last_winner_ls <= 1'b0;
    else if (if_gnt) last_winner_ls <= 1'b0;
    else if (ls_gnt) last_winner_ls <= 1'b1;
  end

  mem_arb_pick u_pick (
    .if_req         (if_req_v),
    .ls_req         (ls_req_v),
    .last_winner_ls (last_winner_ls),
    .if_gnt         (if_gnt),
    .ls_gnt         (ls_gnt)
  );
`else
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (if_gnt)
      starve_cnt <= '0;
    else if (if_req_v && ls_gnt && starve_cnt != CNT_W'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req     (if_req_v),
    .ls_req     (ls_req_v),
    .starve_cnt (starve_cnt),
    .if_gnt     (if_gnt),
    .ls_gnt     (ls_gnt)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) owner <= SRC_NONE;
    else     owner <= owner_nxt;
  end

  always_comb begin
    owner_nxt = SRC_NONE;
    if (if_gnt)                owner_nxt = SRC_IF;
    else if (ls_gnt && !ls_we) owner_nxt = SRC_LS_RD;
  end

  // Gating with rst kills a return that was in flight when reset arrived.
  always_comb begin
    if_rvalid = (owner == SRC_IF)    & ~rst;
    ls_rvalid = (owner == SRC_LS_RD) & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr  <= '0;
      last_wdata <= '0;
    end else if (if_gnt) begin
      last_addr  <= if_addr;
    end else if (ls_gnt) begin
      last_addr  <= ls_addr;
      last_wdata <= ls_wdata;
    end
  end

  always_comb begin
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    mem_we    = 1'b0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_we    = ls_we;
    end
  end

  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural byte memory, read-data scoreboard and arbitration pattern checks.
// Expected grant pattern follows ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;
  import bf8b_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [7:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic       if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we;
  logic [7:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
  end

  // Synchronous memory, write-first on a same-edge read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  a_if_hold: assert property (@(posedge clk) disable iff (rst) (if_req && !if_gnt) |=> if_req)
    else $error("if_req dropped before grant");
  a_ls_hold: assert property (@(posedge clk) disable iff (rst) (ls_req && !ls_gnt) |=> ls_req)
    else $error("ls_req dropped before grant");

  // Scoreboard: grants push expected read data, rvalid pops and compares.
  logic [7:0] if_q[$];
  logic [7:0] ls_q[$];
  logic       exp_if_rv = 1'b0, exp_ls_rv = 1'b0;
  bit         mon_en = 1'b0;
  int         we_cnt = 0;
  int         we0;
  logic [1:0] exp_pat;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        if_q.delete();
        ls_q.delete();
        exp_if_rv = 1'b0;
        exp_ls_rv = 1'b0;
        chk("rst_gnt", {if_gnt, ls_gnt}, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
      end else begin
        chk("gnt_onehot", if_gnt & ls_gnt, 0);
        chk("if_rvalid", if_rvalid, exp_if_rv);
        chk("ls_rvalid", ls_rvalid, exp_ls_rv);
        if (if_rvalid) begin
          if (if_q.size() == 0) chk("if_q_underflow", 1, 0);
          else chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (ls_rvalid) begin
          if (ls_q.size() == 0) chk("ls_q_underflow", 1, 0);
          else chk("ls_rdata", ls_rdata, ls_q.pop_front());
        end
        exp_if_rv = if_gnt;
        exp_ls_rv = ls_gnt & ~ls_we;
        if (if_gnt) if_q.push_back(ref_mem[if_addr]);
        if (ls_gnt) begin
          if (ls_we) ref_mem[ls_addr] = ls_wdata;
          else       ls_q.push_back(ref_mem[ls_addr]);
        end
        if (mem_we) we_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    step();
    rst = 1'b0;

    // IF only, back-to-back fetches 0x00..0x05
    if_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if_addr = 8'(i);
      @(negedge clk);
      chk("t1_if_gnt", if_gnt, 1);
      chk("t1_mem_addr", mem_addr, i);
      step();
    end
    if_req = 1'b0;
    step();
    step();

    // Store 0xAB @0xE0 then load @0xE0
    we0 = we_cnt;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'hE0; ls_wdata = 8'hAB;
    @(negedge clk);
    chk("t2_st_gnt", ls_gnt, 1);
    chk("t2_st_we", mem_we, 1);
    chk("t2_st_wdata", mem_wdata, 8'hAB);
    step();
    ls_we = 1'b0; ls_wdata = 8'h00;
    @(negedge clk);
    chk("t2_ld_gnt", ls_gnt, 1);
    chk("t2_ld_we", mem_we, 0);
    step();
    ls_req = 1'b0;
    @(negedge clk);
    chk("t2_ls_rvalid", ls_rvalid, 1);
    chk("t2_ls_rdata", ls_rdata, 8'hAB);
    chk("t2_we_count", we_cnt - we0, 1);
    step();

    // Store @0x42 then idle
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h42; ls_wdata = 8'h77;
    @(negedge clk);
    chk("t6_st_gnt", ls_gnt, 1);
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 8'h00; ls_wdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_hold_addr", mem_addr, 8'h42);
      chk("t6_hold_wdata", mem_wdata, 8'h77);
      chk("t6_idle_we", mem_we, 0);
      chk("t6_idle_rvalid", {if_rvalid, ls_rvalid}, 0);
      step();
    end

    // Contention: both held every cycle from a fresh reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 8'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h30;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_pat = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_pat = (i % 4 == 3) ? 2'b10 : 2'b01;
`endif
      chk("arb_pattern", {if_gnt, ls_gnt}, exp_pat);
      step();
    end
    rst = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Load @0x10 granted, reset the next cycle
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h10;
    @(negedge clk);
    chk("t5_ld_gnt", ls_gnt, 1);
    step();
    rst = 1'b1;
    ls_req = 1'b0;
    @(negedge clk);
    chk("t5_ls_rvalid_kill", ls_rvalid, 0);
    step();
    if_req = 1'b1; if_addr = 8'h05;
    @(negedge clk);
    chk("t5_rst_if_gnt", if_gnt, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    chk("t5_rst_mem_wdata", mem_wdata, 0);
    chk("t5_rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_ls_rvalid", ls_rvalid, 0);
    chk("t5_post_if_gnt", if_gnt, 1);
    step();
    if_req = 1'b0;
    step();
    step();

    chk("queues_drained", if_q.size() + ls_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
